// File: rtl/encoder_input_filter.sv
// Conditions the raw encoder phases and push-button: two-flop sync, per-input
// debounce, then registered step/direction, button-edge and error pulses.
module encoder_input_filter #(
    parameter int DEBOUNCE = 1000,
    parameter int DB_W     = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic p1_raw,
    input  logic p2_raw,
    input  logic btn_raw,
    output logic p1,
    output logic p2,
    output logic btn,
    output logic step_valid,
    output logic step_dir,
    output logic btn_down,
    output logic btn_up,
    output logic err
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE - 1);

    // Bit 0 = phase A, bit 1 = phase B, bit 2 = button.
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stable;
    logic [DB_W-1:0] cnt [3];
    logic [1:0]      cur;
    logic [1:0]      prev;
    logic            prev_btn;
    logic            fwd;
    logic            rev;
    logic            bad;

    assign raw = {btn_raw, p2_raw, p1_raw};
    assign cur = {stable[0], stable[1]};

    assign p1  = stable[0];
    assign p2  = stable[1];
    assign btn = stable[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A flip needs DEBOUNCE consecutive synced samples that disagree with stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        bad = 1'b0;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev       <= '0;
            prev_btn   <= 1'b0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            err        <= 1'b0;
            btn_down   <= 1'b0;
            btn_up     <= 1'b0;
        end else begin
            prev       <= cur;
            prev_btn   <= stable[2];
            step_valid <= fwd | rev;
            step_dir   <= fwd;
            err        <= bad;
            btn_down   <= stable[2] & ~prev_btn;
            btn_up     <= ~stable[2] & prev_btn;
        end
    end

endmodule

// File: tb/tb_encoder_input_filter.sv
// Self-checking bench for encoder_input_filter with DEBOUNCE=4: vector table,
// directed latency/bounce/reset sequences and a random run against a window model.
`timescale 1ns/1ps
module tb_encoder_input_filter;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    logic p1_raw, p2_raw, btn_raw;
    logic p1, p2, btn, step_valid, step_dir, btn_down, btn_up, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    encoder_input_filter #(.DEBOUNCE(DB), .DB_W(4)) dut (
        .clk(clk), .rst(rst),
        .p1_raw(p1_raw), .p2_raw(p2_raw), .btn_raw(btn_raw),
        .p1(p1), .p2(p2), .btn(btn),
        .step_valid(step_valid), .step_dir(step_dir),
        .btn_down(btn_down), .btn_up(btn_up), .err(err)
    );

    // Reference model: sync is a 2-deep delay, a stable level flips when the
    // last DB synced samples all disagree with it; steps come from the change
    // in Gray-code position of the stable pair.
    logic m_s1 [3];
    logic m_s2 [3];
    logic m_hist [3][DB];
    logic m_stable [3];
    logic m_prev [3];
    logic m_sv = 0, m_dir = 0, m_bd = 0, m_bu = 0, m_err = 0;
    int   m_delta;
    logic m_all;

    function automatic int gpos(logic a, logic b);
        return a ? (b ? 2 : 3) : (b ? 1 : 0);
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_prev[i] = 0;
            for (int j = 0; j < DB; j++) m_hist[i][j] = 0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_prev[i] = 0;
                for (int j = 0; j < DB; j++) m_hist[i][j] = 0;
            end
            m_sv = 0; m_dir = 0; m_bd = 0; m_bu = 0; m_err = 0;
        end else begin
            m_delta = (gpos(m_stable[0], m_stable[1]) - gpos(m_prev[0], m_prev[1]) + 4) % 4;
            m_sv  = (m_delta == 1) || (m_delta == 3);
            m_dir = (m_delta == 1);
            m_err = (m_delta == 2);
            m_bd  = m_stable[2] && !m_prev[2];
            m_bu  = !m_stable[2] && m_prev[2];
            for (int i = 0; i < 3; i++) m_prev[i] = m_stable[i];
            for (int i = 0; i < 3; i++) begin
                for (int j = DB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = m_s2[i];
                m_all = 1;
                for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_stable[i]) m_all = 0;
                if (m_all) m_stable[i] = m_s2[i];
            end
            for (int i = 0; i < 3; i++) m_s2[i] = m_s1[i];
            m_s1[0] = p1_raw; m_s1[1] = p2_raw; m_s1[2] = btn_raw;
        end
    end

    task automatic applyStimulus(input logic a, input logic b, input logic k);
        p1_raw  = a;
        p2_raw  = b;
        btn_raw = k;
    endtask

    task automatic checkOutput();
        logic [7:0] got, exp;
        got = {p1, p2, btn, step_valid, step_dir, btn_down, btn_up, err};
        exp = {m_stable[0], m_stable[1], m_stable[2], m_sv, m_dir, m_bd, m_bu, m_err};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL model t=%0t: got %b expected %b", $time, got, exp);
        end
    endtask

    task automatic expectInt(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    typedef struct {
        logic a, b, k;
        int   hold;
        int   fwd, rev, errs, downs, ups;
    } vec_t;

    vec_t vecs [14];
    int   c_fwd, c_rev, c_err, c_dn, c_up;

    initial begin
        vecs[0]  = '{0, 1, 0, 10, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 10, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 10, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 10, 1, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 10, 0, 1, 0, 0, 0};
        vecs[5]  = '{1, 1, 0, 10, 0, 1, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 10, 0, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 10, 0, 1, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 10, 0, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 10, 0, 0, 1, 0, 0};
        vecs[10] = '{0, 0, 1, 20, 0, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 0, 10, 0, 0, 0, 0, 1};
        vecs[12] = '{0, 1, 1, 10, 1, 0, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 10, 0, 1, 0, 0, 1};

        // Reset held while pins toggle: every output must stay low.
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(logic'(i % 2), logic'((i + 1) % 2), logic'(i % 2));
            tick();
            expectInt("reset_outputs", int'({p1, p2, btn, step_valid, step_dir, btn_down, btn_up, err}), 0);
        end
        rst = 1'b1;
        applyStimulus(0, 0, 0);
        c_fwd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            c_fwd += int'(step_valid) + int'(err) + int'(btn_down) + int'(btn_up);
        end
        expectInt("idle_pulses", c_fwd, 0);

        // Vector table: pulse counts and final stable levels per hold.
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b, vecs[v].k);
            c_fwd = 0; c_rev = 0; c_err = 0; c_dn = 0; c_up = 0;
            for (int c = 0; c < vecs[v].hold; c++) begin
                tick();
                c_fwd += int'(step_valid && step_dir);
                c_rev += int'(step_valid && !step_dir);
                c_err += int'(err);
                c_dn  += int'(btn_down);
                c_up  += int'(btn_up);
            end
            expectInt($sformatf("vec%0d_fwd", v), c_fwd, vecs[v].fwd);
            expectInt($sformatf("vec%0d_rev", v), c_rev, vecs[v].rev);
            expectInt($sformatf("vec%0d_err", v), c_err, vecs[v].errs);
            expectInt($sformatf("vec%0d_down", v), c_dn, vecs[v].downs);
            expectInt($sformatf("vec%0d_up", v), c_up, vecs[v].ups);
            expectInt($sformatf("vec%0d_level", v), int'({p1, p2, btn}),
                      int'({vecs[v].a, vecs[v].b, vecs[v].k}));
        end

        // Exact latency of a forward step: level after edge 5, pulse after edge 6.
        applyStimulus(0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            expectInt($sformatf("lat_p2_e%0d", k), int'(p2), int'(k >= 5));
            expectInt($sformatf("lat_sv_e%0d", k), int'(step_valid), int'(k == 6));
            expectInt($sformatf("lat_dir_e%0d", k), int'(step_dir), int'(k == 6));
        end
        applyStimulus(0, 0, 0);
        repeat (10) tick();

        // Bounce shorter than the debounce window never reaches stable.
        c_fwd = 0;
        for (int r = 0; r < 5; r++) begin
            applyStimulus(0, 1, 0);
            repeat (3) begin tick(); c_fwd += int'(p2) + int'(step_valid) + int'(err); end
            applyStimulus(0, 0, 0);
            repeat (2) begin tick(); c_fwd += int'(p2) + int'(step_valid) + int'(err); end
        end
        expectInt("bounce_quiet", c_fwd, 0);
        applyStimulus(0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            expectInt($sformatf("bounce_p2_e%0d", k), int'(p2), int'(k >= 5));
            expectInt($sformatf("bounce_fwd_e%0d", k), int'(step_valid && step_dir), int'(k == 6));
        end
        applyStimulus(0, 0, 0);
        repeat (10) tick();

        // Reset mid-debounce discards the partial button count.
        applyStimulus(0, 0, 1);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        expectInt("midreset_btn", int'({btn, btn_down}), 0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            expectInt($sformatf("rbtn_level_e%0d", k), int'(btn), int'(k >= 5));
            expectInt($sformatf("rbtn_down_e%0d", k), int'(btn_down), int'(k == 6));
        end

        // Random pins with random holds and occasional resets, model-checked.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(1, 9)) tick();
        end
        rst = 1'b1;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
